// File: rtl/pc_predict_unit_pkg.sv
// Shared types and constants for the IF-stage next-PC generator and its branch history table.
package pc_predict_unit_pkg;

  localparam logic [1:0] BHT_SNT = 2'd0;
  localparam logic [1:0] BHT_WNT = 2'd1;
  localparam logic [1:0] BHT_WT  = 2'd2;
  localparam logic [1:0] BHT_ST  = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    SRC_REDIR,
    SRC_PEND,
    SRC_JAL,
    SRC_BR,
    SRC_HOLD,
    SRC_SEQ
  } next_src_e;

  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == BHT_ST) ? BHT_ST : cnt + 2'd1;
    else       return (cnt == BHT_SNT) ? BHT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/pc_predict_unit_bht_2bit.sv
// Table of 2-bit saturating branch counters, indexed by PC word-address bits.
module bht_2bit
  import pc_predict_unit_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int XLEN        = 32,
  localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rd_pc_i,
  output logic            pred_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i
);

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       cnt_q [BHT_ENTRIES];
  logic [1:0]       cnt_d [BHT_ENTRIES];
  logic             unused_pc_bits;

  assign rd_idx  = rd_pc_i[IDX_W+1:2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign unused_pc_bits = ^{rd_pc_i[XLEN-1:IDX_W+2], rd_pc_i[1:0],
                            upd_pc_i[XLEN-1:IDX_W+2], upd_pc_i[1:0]};

  // Read sees the pre-update counter; no bypass from a same-cycle update.
  assign pred_o = cnt_q[rd_idx][1];

  always_comb begin
    cnt_d = cnt_q;
    if (upd_valid_i) cnt_d[upd_idx] = bht_next(cnt_q[upd_idx], upd_taken_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) cnt_q[i] <= BHT_WNT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with EX redirects, IF jumps, BHT prediction and a stall-time redirect buffer.
module pc_predict_unit
  import pc_predict_unit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC),
  parameter int              BHT_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            if_jal_i,
  input  logic            if_branch_i,
  input  logic            if_jalr_i,
  input  logic [XLEN-1:0] if_imm_i,
  input  logic            ex_branch_i,
  input  logic            ex_taken_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_jalr_i,
  input  logic [XLEN-1:0] ex_jalr_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            pred_taken_o,
  output logic            flush_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic            mispred, redir, bht_pred;
  logic [XLEN-1:0] fix_target, redir_target;
  next_src_e       src;

  bht_2bit #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .XLEN        (XLEN)
  ) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_pc_i     (pc_q),
    .pred_o      (bht_pred),
    .upd_valid_i (ex_branch_i),
    .upd_pc_i    (ex_pc_i),
    .upd_taken_i (ex_taken_i)
  );

  assign mispred      = ex_branch_i & (ex_taken_i != ex_pred_taken_i);
  assign fix_target   = ex_taken_i ? ex_target_i : ex_pc_i + XLEN'(4);
  assign redir        = ex_jalr_i | mispred;
  assign redir_target = ex_jalr_i ? ex_jalr_target_i : fix_target;

  assign pc_o         = pc_q;
  assign pc_plus4_o   = pc_q + XLEN'(4);
  assign pred_taken_o = if_branch_i & bht_pred;
  assign flush_o      = redir;

  always_comb begin
    src = SRC_SEQ;
    if (redir)                              src = SRC_REDIR;
    else if (pend_valid_q)                  src = SRC_PEND;
    else if (if_jal_i)                      src = SRC_JAL;
    else if (if_branch_i && pred_taken_o)   src = SRC_BR;
    else if (if_jalr_i)                     src = SRC_HOLD;

    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;

    if (stall_i) begin
      // Latest redirect seen during the stall is the one that must win.
      if (redir) begin
        pend_valid_d  = 1'b1;
        pend_target_d = redir_target;
      end
    end else begin
      pend_valid_d = 1'b0;
      case (src)
        SRC_REDIR: pc_d = redir_target;
        SRC_PEND:  pc_d = pend_target_q;
        SRC_JAL,
        SRC_BR:    pc_d = pc_q + if_imm_i;
        SRC_HOLD:  pc_d = pc_q;
        default:   pc_d = pc_plus4_o;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit: directed scenarios with literal expectations, then random traffic vs a behavioural model.
module tb_pc_predict_unit;

  localparam int          XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          NBHT   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i, if_jal_i, if_branch_i, if_jalr_i;
  logic [31:0] if_imm_i;
  logic        ex_branch_i, ex_taken_i, ex_pred_taken_i, ex_jalr_i;
  logic [31:0] ex_pc_i, ex_target_i, ex_jalr_target_i;
  logic [31:0] pc_o, pc_plus4_o;
  logic        pred_taken_o, flush_o;

  pc_predict_unit #(
    .XLEN        (XLEN),
    .RESET_PC    (RST_PC),
    .BHT_ENTRIES (NBHT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .if_jal_i         (if_jal_i),
    .if_branch_i      (if_branch_i),
    .if_jalr_i        (if_jalr_i),
    .if_imm_i         (if_imm_i),
    .ex_branch_i      (ex_branch_i),
    .ex_taken_i       (ex_taken_i),
    .ex_pred_taken_i  (ex_pred_taken_i),
    .ex_pc_i          (ex_pc_i),
    .ex_target_i      (ex_target_i),
    .ex_jalr_i        (ex_jalr_i),
    .ex_jalr_target_i (ex_jalr_target_i),
    .pc_o             (pc_o),
    .pc_plus4_o       (pc_plus4_o),
    .pred_taken_o     (pred_taken_o),
    .flush_o          (flush_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_pend_v;
  logic [31:0] m_pend_t;
  int          m_bht [NBHT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    stall_i = 0; if_jal_i = 0; if_branch_i = 0; if_jalr_i = 0; if_imm_i = 0;
    ex_branch_i = 0; ex_taken_i = 0; ex_pred_taken_i = 0; ex_jalr_i = 0;
    ex_pc_i = 0; ex_target_i = 0; ex_jalr_target_i = 0;
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    m_pend_v = 0;
    m_pend_t = 0;
    for (int i = 0; i < NBHT; i++) m_bht[i] = 1;
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % NBHT);
  endfunction

  // Called just after a rising edge with inputs applied; checks at the falling edge,
  // then advances the model across the next rising edge.
  task automatic cycle();
    logic        e_pred, mis, redir;
    logic [31:0] tgt, n_pc, n_pt;
    logic        n_pv;
    @(negedge clk);
    e_pred = if_branch_i && (m_bht[idx_of(m_pc)] >= 2);
    mis    = ex_branch_i && (ex_taken_i != ex_pred_taken_i);
    redir  = ex_jalr_i || mis;
    tgt    = ex_jalr_i ? ex_jalr_target_i : (ex_taken_i ? ex_target_i : ex_pc_i + 32'd4);
    chk("pc_o", pc_o, m_pc);
    chk("pc_plus4_o", pc_plus4_o, m_pc + 32'd4);
    chk("pred_taken_o", {31'b0, pred_taken_o}, {31'b0, e_pred});
    chk("flush_o", {31'b0, flush_o}, {31'b0, redir});
    n_pc = m_pc; n_pv = m_pend_v; n_pt = m_pend_t;
    if (stall_i) begin
      if (redir) begin n_pv = 1; n_pt = tgt; end
    end else begin
      n_pv = 0;
      if (redir)                      n_pc = tgt;
      else if (m_pend_v)              n_pc = m_pend_t;
      else if (if_jal_i)              n_pc = m_pc + if_imm_i;
      else if (if_branch_i && e_pred) n_pc = m_pc + if_imm_i;
      else if (if_jalr_i)             n_pc = m_pc;
      else                            n_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    if (ex_branch_i) begin
      int k;
      k = idx_of(ex_pc_i);
      if (ex_taken_i) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
      else            m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
    end
    m_pc = n_pc; m_pend_v = n_pv; m_pend_t = n_pt;
    #1;
  endtask

  task automatic jump_to(input logic [31:0] t);
    clear_inputs();
    ex_jalr_i = 1; ex_jalr_target_i = t;
    cycle();
    clear_inputs();
  endtask

  task automatic ex_upd(input logic [31:0] pc, input logic taken);
    clear_inputs();
    ex_branch_i = 1; ex_pc_i = pc; ex_taken_i = taken; ex_pred_taken_i = taken;
    cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;

    // Reset and sequential fetch
    chk("reset_pc", pc_o, 32'h100);
    chk("reset_plus4", pc_plus4_o, 32'h104);
    cycle();
    chk("seq_pc1", pc_o, 32'h104);
    if_branch_i = 1; if_imm_i = 32'h40;
    #1 chk("reset_pred_wnt", {31'b0, pred_taken_o}, 32'h0);
    cycle();
    clear_inputs();
    chk("seq_pc2", pc_o, 32'h108);

    // Branch at 0x200 with WNT counter, then train to taken
    jump_to(32'h200);
    chk("jump_200", pc_o, 32'h200);
    if_branch_i = 1; if_imm_i = 32'h40;
    #1 chk("br_pred_wnt", {31'b0, pred_taken_o}, 32'h0);
    cycle();
    chk("br_not_taken_pc", pc_o, 32'h204);
    ex_upd(32'h200, 1);
    ex_upd(32'h200, 1);
    jump_to(32'h200);
    if_branch_i = 1; if_imm_i = 32'h40;
    #1 chk("br_pred_trained", {31'b0, pred_taken_o}, 32'h1);
    cycle();
    clear_inputs();
    chk("br_taken_pc", pc_o, 32'h240);

    // Mispredict: predicted taken, actually not taken
    ex_branch_i = 1; ex_taken_i = 0; ex_pred_taken_i = 1; ex_pc_i = 32'h300;
    #1 chk("mispred_flush", {31'b0, flush_o}, 32'h1);
    cycle();
    clear_inputs();
    chk("mispred_pc", pc_o, 32'h304);

    // Redirect arriving during a 3-cycle stall
    stall_i = 1; ex_jalr_i = 1; ex_jalr_target_i = 32'h800;
    #1 chk("stall_flush", {31'b0, flush_o}, 32'h1);
    cycle();
    ex_jalr_i = 0;
    cycle();
    cycle();
    chk("stall_hold", pc_o, 32'h304);
    stall_i = 0;
    cycle();
    chk("pend_taken", pc_o, 32'h800);

    // Priority: JALR redirect over mispredict over IF jal
    ex_jalr_i = 1; ex_jalr_target_i = 32'h900;
    ex_branch_i = 1; ex_taken_i = 1; ex_pred_taken_i = 0; ex_pc_i = 32'h500; ex_target_i = 32'h700;
    if_jal_i = 1; if_imm_i = 32'h40;
    cycle();
    clear_inputs();
    chk("prio_jalr", pc_o, 32'h900);

    // New redirect in the cycle stall drops beats the pending one
    stall_i = 1; ex_jalr_i = 1; ex_jalr_target_i = 32'hA00;
    cycle();
    stall_i = 0; ex_jalr_target_i = 32'hB00;
    cycle();
    clear_inputs();
    chk("redir_over_pend", pc_o, 32'hB00);
    cycle();
    chk("pend_cleared", pc_o, 32'hB04);

    // Wrap-around
    jump_to(32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4_o, 32'h0);
    cycle();
    chk("wrap_pc", pc_o, 32'h0);

    // Saturation at ST: 3 taken from WNT, then two not-taken steps
    ex_upd(32'h44, 1);
    ex_upd(32'h44, 1);
    ex_upd(32'h44, 1);
    ex_upd(32'h44, 0);
    jump_to(32'h44);
    if_branch_i = 1;
    #1 chk("sat_wt_pred", {31'b0, pred_taken_o}, 32'h1);
    clear_inputs();
    ex_upd(32'h44, 0);
    jump_to(32'h44);
    if_branch_i = 1;
    #1 chk("sat_wnt_pred", {31'b0, pred_taken_o}, 32'h0);
    clear_inputs();

    // Reset mid-stall drops the pending redirect
    stall_i = 1; ex_jalr_i = 1; ex_jalr_target_i = 32'hC00;
    cycle();
    clear_inputs();
    rst_n = 0;
    model_reset();
    #2 chk("rst_mid_stall_pc", pc_o, 32'h100);
    rst_n = 1;
    cycle();
    chk("rst_pend_dropped", pc_o, 32'h104);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      stall_i          = ($urandom_range(0, 3) == 0);
      if_jal_i         = ($urandom_range(0, 9) == 0);
      if_branch_i      = ($urandom_range(0, 9) < 3);
      if_jalr_i        = ($urandom_range(0, 19) == 0);
      if_imm_i         = 32'($signed($urandom_range(0, 511)) - 256) << 2;
      ex_branch_i      = ($urandom_range(0, 9) < 3);
      ex_taken_i       = $urandom_range(0, 1);
      ex_pred_taken_i  = ($urandom_range(0, 3) == 0) ? ~ex_taken_i : ex_taken_i;
      ex_pc_i          = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      ex_target_i      = $urandom;
      ex_jalr_i        = ($urandom_range(0, 11) == 0);
      ex_jalr_target_i = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
